// File: rtl/picomips_mc_core_pkg.sv
// Shared definitions for the multi-cycle picoMIPS core: opcodes, FSM states
// and ALU function codes.
package cpuConfig;

    localparam int OP_SIZE_DEFAULT = 6;

    typedef enum logic [OP_SIZE_DEFAULT-1:0] {
        OP_NOP   = 6'h00,
        OP_ADD   = 6'h01,
        OP_ADDI  = 6'h02,
        OP_SUB   = 6'h03,
        OP_SUBI  = 6'h04,
        OP_MULH  = 6'h05,
        OP_MULHI = 6'h06,
        OP_LDSW  = 6'h07,
        OP_WAITSW= 6'h08,
        OP_BEQ   = 6'h09,
        OP_BNE   = 6'h0A,
        OP_JMP   = 6'h0B,
        OP_OUT   = 6'h0C,
        OP_HALT  = 6'h3F
    } opcode_t;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_WAIT_SW,
        S_WRITEBACK,
        S_HALT
    } mcState_t;

    typedef enum logic [2:0] {
        ALU_PASSB,
        ALU_ADD,
        ALU_SUB,
        ALU_MULH
    } aluFunc_t;

endpackage

// File: rtl/picomips_mc_core_regfile.sv
// Register file: two asynchronous read ports, one synchronous write port,
// register 0 hardwired to zero.
module mc_regfile #(
    parameter int N      = 8,
    parameter int R_SIZE = 3
) (
    input  logic              clk,
    input  logic              nRst,
    input  logic              we,
    input  logic [R_SIZE-1:0] waddr,
    input  logic [N-1:0]      wdata,
    input  logic [R_SIZE-1:0] raddra,
    input  logic [R_SIZE-1:0] raddrb,
    output logic [N-1:0]      rdataa,
    output logic [N-1:0]      rdatab
);

    logic [N-1:0] regs [0:(2**R_SIZE)-1];

    // Clear everything on reset; writes to register 0 are dropped.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            for (int i = 0; i < 2**R_SIZE; i++) regs[i] <= '0;
        end else if (we && (waddr != '0)) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdataa = (raddra == '0) ? '0 : regs[raddra];
    assign rdatab = (raddrb == '0) ? '0 : regs[raddrb];

endmodule

// File: rtl/picomips_mc_core.sv
// Multi-cycle picoMIPS core: FETCH/DECODE/EXECUTE/(WAIT_SW)/WRITEBACK FSM
// against a synchronous ROM with one-cycle read latency.
module picomips_mc_core #(
    parameter int N      = 8,
    parameter int O_SIZE = 6,
    parameter int P_SIZE = 5,
    parameter int R_SIZE = 3,
    parameter int I_SIZE = O_SIZE + 2*R_SIZE + N
) (
    input  logic              clk,
    input  logic              nRst,
    input  logic [I_SIZE-1:0] instrData,
    input  logic [9:0]        switchesIn,
    output logic [P_SIZE-1:0] instrAddr,
    output logic [N-1:0]      displayResult,
    output logic [P_SIZE-1:0] displayPC,
    output logic              halted
);
    import cpuConfig::*;

    mcState_t          state, state_nx;
    logic [P_SIZE-1:0] pc;
    logic [I_SIZE-1:0] ir;
    logic [N-1:0]      res_q;
    logic              take_q;
    logic              sync0, sync1, sync2, edge_flag;

    logic [O_SIZE-1:0] ir_op;
    logic [R_SIZE-1:0] ir_rd, ir_rs;
    logic [N-1:0]      ir_imm;
    opcode_t           opc;
    logic [N-1:0]      ra, rb, opa, opb, alu_res;
    aluFunc_t          alu_fn;
    logic              writes, is_out, take;

    assign ir_op  = ir[I_SIZE-1 -: O_SIZE];
    assign ir_rd  = ir[N+2*R_SIZE-1 -: R_SIZE];
    assign ir_rs  = ir[N+R_SIZE-1 -: R_SIZE];
    assign ir_imm = ir[N-1:0];
    // The opcode values live in the low six bits of the opcode field.
    assign opc    = opcode_t'(6'(ir_op));

    // Q1.(N-1) fractional multiply; only min x min overflows and saturates.
    function automatic logic [N-1:0] fmul(input logic [N-1:0] a, input logic [N-1:0] b);
        logic signed [2*N-1:0] sa, sb, p;
        logic [N-1:0]          minv;
        minv = {1'b1, {(N-1){1'b0}}};
        sa   = {{N{a[N-1]}}, a};
        sb   = {{N{b[N-1]}}, b};
        p    = sa * sb;
        if ((a == minv) && (b == minv)) return {1'b0, {(N-1){1'b1}}};
        return p[2*N-2:N-1];
    endfunction

    mc_regfile #(.N(N), .R_SIZE(R_SIZE)) u_regfile (
        .clk    (clk),
        .nRst   (nRst),
        .we     ((state == S_WRITEBACK) && writes),
        .waddr  (ir_rd),
        .wdata  (res_q),
        .raddra (ir_rd),
        .raddrb (ir_rs),
        .rdataa (ra),
        .rdatab (rb)
    );

    // Decode the IR into ALU operands, function, write enable and branch decision.
    always_comb begin
        alu_fn = ALU_PASSB;
        opa    = ra;
        opb    = rb;
        writes = 1'b0;
        is_out = 1'b0;
        take   = 1'b0;
        case (opc)
            OP_ADD:   begin alu_fn = ALU_ADD;  writes = 1'b1; end
            OP_ADDI:  begin alu_fn = ALU_ADD;  opa = rb; opb = ir_imm; writes = 1'b1; end
            OP_SUB:   begin alu_fn = ALU_SUB;  writes = 1'b1; end
            OP_SUBI:  begin alu_fn = ALU_SUB;  opa = rb; opb = ir_imm; writes = 1'b1; end
            OP_MULH:  begin alu_fn = ALU_MULH; writes = 1'b1; end
            OP_MULHI: begin alu_fn = ALU_MULH; opa = rb; opb = ir_imm; writes = 1'b1; end
            OP_LDSW:  begin opb = N'(switchesIn[7:0]); writes = 1'b1; end
            OP_BEQ:   take = (ra == rb);
            OP_BNE:   take = (ra != rb);
            OP_JMP:   take = 1'b1;
            OP_OUT:   is_out = 1'b1;
            default:  ;
        endcase
        case (alu_fn)
            ALU_ADD:  alu_res = opa + opb;
            ALU_SUB:  alu_res = opa - opb;
            ALU_MULH: alu_res = fmul(opa, opb);
            default:  alu_res = opb;
        endcase
    end

    // Next-state logic of the instruction sequencer.
    always_comb begin
        state_nx = state;
        case (state)
            S_FETCH:     state_nx = S_DECODE;
            S_DECODE:    state_nx = S_EXECUTE;
            S_EXECUTE: begin
                if (opc == OP_WAITSW)    state_nx = S_WAIT_SW;
                else if (opc == OP_HALT) state_nx = S_HALT;
                else                     state_nx = S_WRITEBACK;
            end
            S_WAIT_SW:   if (edge_flag) state_nx = S_WRITEBACK;
            S_WRITEBACK: state_nx = S_FETCH;
            S_HALT:      state_nx = S_HALT;
            default:     state_nx = S_FETCH;
        endcase
    end

    // State register plus IR, result, branch flag, PC and display updates.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state         <= S_FETCH;
            pc            <= '0;
            ir            <= '0;
            res_q         <= '0;
            take_q        <= 1'b0;
            displayResult <= '0;
        end else begin
            state <= state_nx;
            case (state)
                S_DECODE:  ir <= instrData;
                S_EXECUTE: begin
                    res_q  <= alu_res;
                    take_q <= take;
                end
                S_WRITEBACK: begin
                    pc <= take_q ? ir_imm[P_SIZE-1:0] : pc + P_SIZE'(1);
                    if (is_out) displayResult <= ra;
                end
                default: ;
            endcase
        end
    end

    // Button synchroniser and rising-edge flag; entering WAIT_SW discards stale edges.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            sync0     <= 1'b0;
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            edge_flag <= 1'b0;
        end else begin
            sync0 <= switchesIn[9];
            sync1 <= sync0;
            sync2 <= sync1;
            if ((state == S_EXECUTE) && (opc == OP_WAITSW)) edge_flag <= 1'b0;
            else if (sync1 && !sync2)                       edge_flag <= 1'b1;
        end
    end

    assign instrAddr = pc;
    assign displayPC = pc;
    assign halted    = (state == S_HALT);

endmodule

// File: tb/tb_picomips_mc_core.sv
// Directed bench for picomips_mc_core: table of single-op programs plus
// hand-written sequences for timing, wrap, branches, button wait and reset.
module tb_picomips_mc_core;

    localparam logic [5:0] NOP = 6'h00, ADD = 6'h01, ADDI = 6'h02, SUB = 6'h03,
                           SUBI = 6'h04, MULH = 6'h05, MULHI = 6'h06, LDSW = 6'h07,
                           WAITSW = 6'h08, BEQ = 6'h09, BNE = 6'h0A, JMP = 6'h0B,
                           OUT = 6'h0C, HALT = 6'h3F;

    logic        clk, nRst;
    logic [19:0] instrData;
    logic [9:0]  switchesIn;
    logic [4:0]  instrAddr, displayPC;
    logic [7:0]  displayResult;
    logic        halted;
    logic [19:0] rom [0:31];

    int n_cmp = 0;
    int n_bad = 0;

    picomips_mc_core dut (
        .clk           (clk),
        .nRst          (nRst),
        .instrData     (instrData),
        .switchesIn    (switchesIn),
        .instrAddr     (instrAddr),
        .displayResult (displayResult),
        .displayPC     (displayPC),
        .halted        (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) instrData <= rom[instrAddr];

    typedef struct {
        string      name;
        logic [5:0] op;
        logic       imm;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] sw;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs [13];

    function automatic logic [19:0] enc(input logic [5:0] op, input logic [2:0] rd,
                                        input logic [2:0] rs, input logic [7:0] imm);
        return {op, rd, rs, imm};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 32; i++) rom[i] = enc(NOP, 0, 0, 0);
    endtask

    task automatic do_reset();
        nRst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        nRst = 1'b1;
    endtask

    task automatic wait_halted(input string name, input int max);
        int c = 0;
        while (!halted && c < max) begin
            tick(1);
            c++;
        end
        chk(name, {31'd0, halted}, 32'd1);
    endtask

    task automatic wait_result(input string name, input logic [7:0] val, input int max);
        int c = 0;
        while (displayResult !== val && c < max) begin
            tick(1);
            c++;
        end
        chk(name, {24'd0, displayResult}, {24'd0, val});
    endtask

    initial begin
        nRst       = 1'b0;
        switchesIn = '0;
        clear_rom();

        vecs[0]  = '{"add",        ADD,   1'b0, 8'h05, 8'h08, 8'h00, 8'h0D};
        vecs[1]  = '{"add_wrap",   ADD,   1'b0, 8'hFF, 8'h02, 8'h00, 8'h01};
        vecs[2]  = '{"addi_wrap",  ADDI,  1'b1, 8'hFF, 8'h02, 8'h00, 8'h01};
        vecs[3]  = '{"sub_neg",    SUB,   1'b0, 8'h03, 8'h05, 8'h00, 8'hFE};
        vecs[4]  = '{"subi",       SUBI,  1'b1, 8'h10, 8'h01, 8'h00, 8'h0F};
        vecs[5]  = '{"mulh_pos",   MULH,  1'b0, 8'h40, 8'h40, 8'h00, 8'h20};
        vecs[6]  = '{"mulh_neg",   MULH,  1'b0, 8'hC0, 8'h40, 8'h00, 8'hE0};
        vecs[7]  = '{"mulh_sat",   MULH,  1'b0, 8'h80, 8'h80, 8'h00, 8'h7F};
        vecs[8]  = '{"mulhi_sat",  MULHI, 1'b1, 8'h80, 8'h80, 8'h00, 8'h7F};
        vecs[9]  = '{"mulhi_neg",  MULHI, 1'b1, 8'h40, 8'hC0, 8'h00, 8'hE0};
        vecs[10] = '{"undef_op",   6'h15, 1'b0, 8'h22, 8'h33, 8'h00, 8'h22};
        vecs[11] = '{"nop",        NOP,   1'b0, 8'h44, 8'h55, 8'h00, 8'h44};
        vecs[12] = '{"ldsw",       LDSW,  1'b0, 8'h11, 8'h22, 8'h5A, 8'h5A};

        // Straight-line program with cycle-exact checks.
        clear_rom();
        rom[0] = enc(ADDI, 1, 0, 8'd5);
        rom[1] = enc(ADDI, 2, 1, 8'd3);
        rom[2] = enc(ADD,  1, 2, 8'd0);
        rom[3] = enc(OUT,  1, 0, 8'd0);
        rom[4] = enc(HALT, 0, 0, 8'd0);
        nRst = 1'b0;
        #1;
        chk("rst_result", {24'd0, displayResult}, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_addr",   {27'd0, instrAddr}, 32'd0);
        chk("rst_pc",     {27'd0, displayPC}, 32'd0);
        do_reset();
        tick(15);
        chk("sl_before_out", {24'd0, displayResult}, 32'd0);
        tick(1);
        chk("sl_out_c16", {24'd0, displayResult}, 32'h0D);
        tick(2);
        chk("sl_not_halted_c18", {31'd0, halted}, 32'd0);
        tick(1);
        chk("sl_halted_c19", {31'd0, halted}, 32'd1);
        chk("sl_pc", {27'd0, displayPC}, 32'd4);

        // Table-driven single-operation programs.
        for (int i = 0; i < 13; i++) begin
            clear_rom();
            switchesIn = {2'b00, vecs[i].sw};
            rom[0] = enc(ADDI, 1, 0, vecs[i].a);
            rom[1] = enc(ADDI, 2, 0, vecs[i].b);
            rom[2] = vecs[i].imm ? enc(vecs[i].op, 1, 1, vecs[i].b)
                                 : enc(vecs[i].op, 1, 2, 8'd0);
            rom[3] = enc(OUT,  1, 0, 8'd0);
            rom[4] = enc(HALT, 0, 0, 8'd0);
            do_reset();
            wait_halted({vecs[i].name, "_halt"}, 60);
            chk(vecs[i].name, {24'd0, displayResult}, {24'd0, vecs[i].exp});
        end
        switchesIn = '0;

        // Wrap and register 0.
        clear_rom();
        rom[0] = enc(ADDI, 1, 0, 8'hFF);
        rom[1] = enc(ADDI, 1, 1, 8'h02);
        rom[2] = enc(ADDI, 0, 0, 8'h07);
        rom[3] = enc(OUT,  1, 0, 8'd0);
        rom[4] = enc(OUT,  0, 0, 8'd0);
        rom[5] = enc(HALT, 0, 0, 8'd0);
        do_reset();
        tick(16);
        chk("wrap_out_r1", {24'd0, displayResult}, 32'h01);
        tick(4);
        chk("r0_out", {24'd0, displayResult}, 32'h00);

        // Counted loop with BNE back-edge and BEQ exit.
        clear_rom();
        rom[0] = enc(ADDI, 1, 0, 8'd3);
        rom[1] = enc(ADDI, 2, 0, 8'd0);
        rom[2] = enc(SUBI, 1, 1, 8'd1);
        rom[3] = enc(ADDI, 2, 2, 8'd1);
        rom[4] = enc(BNE,  1, 0, 8'd2);
        rom[5] = enc(BEQ,  1, 0, 8'd7);
        rom[6] = enc(HALT, 0, 0, 8'd0);
        rom[7] = enc(OUT,  2, 0, 8'd0);
        rom[8] = enc(HALT, 0, 0, 8'd0);
        do_reset();
        wait_halted("loop_halt", 200);
        chk("loop_iters", {24'd0, displayResult}, 32'd3);
        chk("loop_exit_pc", {27'd0, displayPC}, 32'd8);

        // Loop starting at address 31, wrapping the PC to 0.
        clear_rom();
        rom[0]  = enc(BNE,  4, 0, 8'd2);
        rom[1]  = enc(JMP,  0, 0, 8'd29);
        rom[2]  = enc(ADDI, 2, 2, 8'd1);
        rom[3]  = enc(BNE,  1, 0, 8'd31);
        rom[4]  = enc(OUT,  2, 0, 8'd0);
        rom[5]  = enc(HALT, 0, 0, 8'd0);
        rom[29] = enc(ADDI, 1, 0, 8'd3);
        rom[30] = enc(ADDI, 4, 0, 8'd1);
        rom[31] = enc(SUBI, 1, 1, 8'd1);
        do_reset();
        wait_halted("wrap_loop_halt", 300);
        chk("wrap_loop_iters", {24'd0, displayResult}, 32'd3);
        chk("wrap_loop_pc", {27'd0, displayPC}, 32'd5);

        // Button wait: stale pulse ignored, held button does not retrigger.
        clear_rom();
        rom[0] = enc(ADDI,   1, 0, 8'd1);
        rom[1] = enc(ADDI,   1, 1, 8'd1);
        rom[2] = enc(WAITSW, 0, 0, 8'd0);
        rom[3] = enc(LDSW,   2, 0, 8'd0);
        rom[4] = enc(OUT,    2, 0, 8'd0);
        rom[5] = enc(WAITSW, 0, 0, 8'd0);
        rom[6] = enc(ADDI,   3, 0, 8'h77);
        rom[7] = enc(OUT,    3, 0, 8'd0);
        rom[8] = enc(HALT,   0, 0, 8'd0);
        do_reset();
        tick(2);
        switchesIn[9] = 1'b1;
        tick(2);
        switchesIn[9] = 1'b0;
        tick(9);
        chk("wait_stale_pc", {27'd0, displayPC}, 32'd2);
        tick(3);
        chk("wait_stale_pc_later", {27'd0, displayPC}, 32'd2);
        chk("wait_stale_result", {24'd0, displayResult}, 32'd0);
        switchesIn = {1'b1, 1'b0, 8'hA5};
        wait_result("wait_ldsw_out", 8'hA5, 40);
        tick(30);
        chk("hold_no_retrigger_pc", {27'd0, displayPC}, 32'd5);
        chk("hold_no_retrigger_out", {24'd0, displayResult}, 32'hA5);
        switchesIn[9] = 1'b0;
        tick(4);
        switchesIn[9] = 1'b1;
        wait_halted("wait2_halt", 60);
        chk("wait2_out", {24'd0, displayResult}, 32'h77);
        switchesIn = '0;

        // Asynchronous reset in the middle of an EXECUTE.
        clear_rom();
        rom[0] = enc(ADDI, 1, 0, 8'h33);
        rom[1] = enc(OUT,  1, 0, 8'd0);
        rom[2] = enc(ADDI, 3, 0, 8'h09);
        rom[3] = enc(OUT,  3, 0, 8'd0);
        rom[4] = enc(HALT, 0, 0, 8'd0);
        do_reset();
        tick(10);
        chk("ar_pre_out", {24'd0, displayResult}, 32'h33);
        chk("ar_pre_pc", {27'd0, displayPC}, 32'd2);
        #1;
        nRst = 1'b0;
        #1;
        chk("ar_out_zero", {24'd0, displayResult}, 32'd0);
        chk("ar_pc_zero", {27'd0, displayPC}, 32'd0);
        chk("ar_addr_zero", {27'd0, instrAddr}, 32'd0);
        chk("ar_halted_zero", {31'd0, halted}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        nRst = 1'b1;
        tick(4);
        chk("ar_restart_pc", {27'd0, displayPC}, 32'd1);
        tick(4);
        chk("ar_restart_out", {24'd0, displayResult}, 32'h33);
        tick(8);
        chk("ar_r3_out", {24'd0, displayResult}, 32'h09);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
